fb_write_arbiter: RTL and testbench

Shares the single frame-buffer RAM write port between two requesters: the ROM-to-RAM loader (port 0) and the image-processing engine (port 1). The block grants one requester per cycle using bounded-burst round-robin and registers the winning write onto the RAM write port. It sits between the loader/engine and the dual-port frame RAM, whose read side feeds the VGA path.

---
 rtl/fb_pkg.sv | 14 +
 rtl/fb_write_arbiter.sv | 110 +++++++++++
 tb/tb_fb_write_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: write-port owner encoding and default geometry.
package fb_pkg;

    localparam int ADDR_W_DEF   = 19;
    localparam int DATA_W_DEF   = 8;
    localparam int FRAME_PIXELS = 160 * 120;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

endpackage

// File: rtl/fb_write_arbiter.sv
// Bounded-burst round-robin arbiter sharing the frame RAM write port between
// the ROM loader (port 0) and the image engine (port 1); the winning write is registered.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic [1:0]        owner,
    output logic              busy
);

    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_below_max;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [ADDR_W-1:0] r_wraddr;
    logic [DATA_W-1:0] r_data;
    logic              r_wren;

    assign w_below_max = (r_cnt < CNT_MAX);
    assign w_cnt_inc   = w_below_max ? (r_cnt + CNT_ONE) : r_cnt;

    // The owner keeps the port until its burst budget is spent while the other side waits.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_OWN0: begin
                    if (req0_valid && (w_below_max || !req1_valid)) w_gnt0 = 1'b1;
                    else if (req1_valid)                            w_gnt1 = 1'b1;
                end
                ST_OWN1: begin
                    if (req1_valid && (w_below_max || !req0_valid)) w_gnt1 = 1'b1;
                    else if (req0_valid)                            w_gnt0 = 1'b1;
                end
                default: begin
                    if (req0_valid)      w_gnt0 = 1'b1;
                    else if (req1_valid) w_gnt1 = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        if (w_gnt0) begin
            w_state_nxt = ST_OWN0;
            w_cnt_nxt   = (r_state == ST_OWN0) ? w_cnt_inc : CNT_ONE;
        end else if (w_gnt1) begin
            w_state_nxt = ST_OWN1;
            w_cnt_nxt   = (r_state == ST_OWN1) ? w_cnt_inc : CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_wren   <= 1'b0;
            r_wraddr <= '0;
            r_data   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wren  <= w_gnt0 || w_gnt1;
            // Address/data hold their last value on idle cycles.
            if (w_gnt0) begin
                r_wraddr <= req0_addr;
                r_data   <= req0_data;
            end else if (w_gnt1) begin
                r_wraddr <= req1_addr;
                r_data   <= req1_data;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign ram_wraddr = r_wraddr;
    assign ram_data   = r_data;
    assign ram_wren   = r_wren;
    assign owner      = r_state;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter with MAX_BURST=4 and directed grant patterns.
module tb_fb_write_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic [AW-1:0] ram_wraddr;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [1:0]    owner;
    logic          busy;

    fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .ram_wraddr(ram_wraddr), .ram_data(ram_data), .ram_wren(ram_wren),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mexp;
    logic [AW-1:0]    p0_addr, p1_addr;
    logic [DW-1:0]    p0_data, p1_data;
    int               cpat[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // One cycle of stimulus: drive at negedge, check readys, queue expected write.
    task automatic step(input logic rst, input logic v0, input logic v1, input int eg, input string tag);
        @(negedge clk);
        reset      = rst;
        req0_valid = v0;
        req0_addr  = p0_addr;
        req0_data  = p0_data;
        req1_valid = v1;
        req1_addr  = p1_addr;
        req1_data  = p1_data;
        #1;
        check1({tag, "/ready0"}, 32'(req0_ready), 32'(eg == 0));
        check1({tag, "/ready1"}, 32'(req1_ready), 32'(eg == 1));
        if (eg == 0) begin
            exp_q.push_back({p0_addr, p0_data});
            p0_addr = p0_addr + 1'b1;
            p0_data = p0_data + 1'b1;
        end else if (eg == 1) begin
            exp_q.push_back({p1_addr, p1_data});
            p1_addr = p1_addr + 1'b1;
            p1_data = p1_data + 1'b1;
        end
    endtask

    task automatic check_owner(input logic [1:0] exp_owner, input string tag);
        check1({tag, "/owner"}, 32'(owner), 32'(exp_owner));
        check1({tag, "/busy"}, 32'(busy), 32'(exp_owner != 2'b00));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (ram_wren === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                             ram_wraddr, ram_data);
                end else begin
                    mexp = exp_q.pop_front();
                    check1("ram_wraddr", 32'(ram_wraddr), 32'(mexp[AW+DW-1:DW]));
                    check1("ram_data", 32'(ram_data), 32'(mexp[DW-1:0]));
                end
            end
        end
    end

    initial begin
        p0_addr = 19'h00100; p0_data = 8'h01;
        p1_addr = 19'h00200; p1_data = 8'h81;

        repeat (2) begin
            step(1'b1, 1'b1, 1'b1, -1, "reset");
            check1("reset/wren", 32'(ram_wren), 32'd0);
            check_owner(2'b00, "reset");
        end

        foreach (cpat[i]) step(1'b0, 1'b1, 1'b1, cpat[i], "contend");
        step(1'b0, 1'b0, 1'b0, -1, "drain");
        step(1'b0, 1'b0, 1'b0, -1, "idle");
        check_owner(2'b00, "after_contend");

        p0_addr = 19'd0; p0_data = 8'h40;
        repeat (10) step(1'b0, 1'b1, 1'b0, 0, "solo");
        check_owner(2'b01, "solo_run");
        step(1'b0, 1'b0, 1'b0, -1, "solo_end");
        step(1'b0, 1'b0, 1'b0, -1, "idle");
        check_owner(2'b00, "solo_done");

        step(1'b0, 1'b0, 1'b1, 1, "early_p1a");
        step(1'b0, 1'b1, 1'b1, 1, "early_p1b");
        step(1'b0, 1'b1, 1'b0, 0, "early_switch");
        check_owner(2'b10, "early_switch");
        repeat (3) step(1'b0, 1'b1, 1'b1, 0, "early_burst");
        step(1'b0, 1'b1, 1'b1, 1, "early_handback");
        step(1'b0, 1'b0, 1'b0, -1, "idle");
        step(1'b0, 1'b0, 1'b0, -1, "idle");
        check_owner(2'b00, "early_done");

        repeat (20) step(1'b0, 1'b1, 1'b0, 0, "sat_solo");
        step(1'b0, 1'b1, 1'b1, 1, "sat_preempt");
        step(1'b0, 1'b1, 1'b0, 0, "sat_back");
        check_owner(2'b10, "sat_back");
        step(1'b0, 1'b0, 1'b0, -1, "idle");
        step(1'b0, 1'b0, 1'b0, -1, "idle");

        p1_addr = 19'h00123; p1_data = 8'hAB;
        repeat (4) step(1'b0, 1'b1, 1'b1, 0, "bp_stall");
        step(1'b0, 1'b1, 1'b1, 1, "bp_grant");
        step(1'b0, 1'b1, 1'b0, 0, "bp_after");
        repeat (3) step(1'b0, 1'b0, 1'b0, -1, "idle");
        check_owner(2'b00, "final");

        check1("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
